user_obi_rr_arbiter: RTL and testbench
======================================

USER_OBI_RR_ARBITER -- requirements
Module: user_obi_rr_arbiter

Interface
REQ-001 SHALL have parameter NumMgr, default 4: number of OBI managers sharing one subordinate port (2..8).
REQ-002 SHALL have parameter MaxTrans, default 2: max outstanding granted-but-unanswered transactions (1..4).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- mgr_req_i  in  NumMgr  per-manager request.
- mgr_addr_i  in  NumMgr*32  per-manager address.
- mgr_we_i  in  NumMgr  per-manager write enable.
- mgr_be_i  in  NumMgr*4  per-manager byte enables.
- mgr_wdata_i  in  NumMgr*32  per-manager write data.
- mgr_gnt_o  out  NumMgr  per-manager grant.
- mgr_rvalid_o  out  NumMgr  per-manager response valid.
- mgr_rdata_o  out  32  response data, broadcast to all managers.
- mgr_err_o  out  1  response error, broadcast to all managers.
- sbr_req_o, sbr_addr_o, sbr_we_o, sbr_be_o, sbr_wdata_o  out  1/32/1/4/32  subordinate request channel.
- sbr_gnt_i, sbr_rvalid_i, sbr_rdata_i, sbr_err_i  in  1/1/32/1  subordinate grant and response.
- busy_o  out  1  high while the request is locked or any response is outstanding.

Function
REQ-005 SHALL implement FSM IDLE/LOCKED plus round-robin pointer ptr (0..NumMgr-1) and owner FIFO (depth MaxTrans, entries are manager indices).
REQ-006 SHALL, in IDLE, select as winner the first asserted mgr_req_i scanning ptr, ptr+1, ... modulo NumMgr.
REQ-007 SHALL drive sbr_req_o = winner valid AND FIFO not full; sbr_addr/we/be/wdata SHALL be muxed from the winner; when sbr_req_o=0 the mux outputs SHALL be 0.
REQ-008 SHALL, on sbr_req_o & sbr_gnt_i, assert mgr_gnt_o[winner] in the same cycle, push winner into the FIFO, set ptr <= (winner+1) mod NumMgr, and stay in or return to IDLE.
REQ-009 SHALL, on sbr_req_o & !sbr_gnt_i, go to LOCKED with lock_idx <= winner; in LOCKED the winner SHALL be lock_idx regardless of other requests until granted, then return to IDLE.
REQ-010 SHALL never assert more than one mgr_gnt_o bit per cycle.
REQ-011 SHALL, on sbr_rvalid_i with FIFO non-empty, assert mgr_rvalid_o[FIFO head] for that cycle with mgr_rdata_o=sbr_rdata_i and mgr_err_o=sbr_err_i, and pop the head.
REQ-012 SHALL ignore sbr_rvalid_i when the FIFO is empty: no mgr_rvalid_o and no state change.
REQ-013 SHALL gate a new request when the FIFO is full, even if a pop occurs in the same cycle; simultaneous push and pop on a non-full FIFO SHALL keep the occupancy unchanged.
REQ-014 SHALL have zero added latency: grant and response paths are combinational from the subordinate inputs.
REQ-015 SHALL drive mgr_rdata_o and mgr_err_o to 0 whenever sbr_rvalid_i is not forwarded.

Reset
REQ-016 SHALL, on rst_i=1 at a clk_i edge, set state=IDLE, ptr=0, FIFO empty, lock_idx=0 and any performance counter to 0.
REQ-017 SHALL, while rst_i is high, drive all outputs combinationally from that reset state; in that state sbr_req_o follows manager requests and busy_o=0.
REQ-018 SHALL discard all in-flight ownership on a reset asserted mid-transaction; responses arriving afterwards are handled per REQ-012.

Configuration
REQ-019 SHALL add, when macro USER_OBI_ARB_PERF_EN is defined, output grant_cnt_o (32 bits): a count of sbr grants that saturates at 0xFFFF_FFFF, plus output stall_cnt_o (32 bits): a saturating count of cycles with sbr_req_o & !sbr_gnt_i.
REQ-020 SHALL, without USER_OBI_ARB_PERF_EN, have neither port nor counter logic; all other behaviour SHALL be identical.

Verification
REQ-021 SHALL cover: NumMgr=4, mgr_req_i=4'b1111 held, sbr_gnt_i=1, responses one cycle later -> grants in order 0,1,2,3,0 on consecutive cycles.
REQ-022 SHALL cover: mgr 2 requests, sbr_gnt_i=0 for 3 cycles while mgr 0 also requests -> sbr_addr_o stays at mgr 2's address (e.g. 0x2000_0010), LOCKED; on gnt, mgr_gnt_o=4'b0100 then mgr 0 granted.
REQ-023 SHALL cover: MaxTrans=2, two grants with no rvalid -> sbr_req_o=0 in the third cycle; a pop followed by one cycle -> request resumes; busy_o=1 throughout.
REQ-024 SHALL cover: grants to mgr 1 then mgr 3, responses 0xDEAD_BEEF (err=0) then 0x1 (err=1) -> mgr_rvalid_o=4'b0010 with data 0xDEAD_BEEF, then 4'b1000 with err=1.
REQ-025 SHALL cover: spurious sbr_rvalid_i with FIFO empty -> mgr_rvalid_o=0; rst_i asserted with 1 outstanding -> busy_o=0 the next cycle, ptr=0.
REQ-026 SHALL cover: with USER_OBI_ARB_PERF_EN, 5 grants and 3 stall cycles -> grant_cnt_o=5 and stall_cnt_o=3.

Source files
------------

// File: rtl/user_obi_rr_arbiter.sv
// Round-robin OBI arbiter: NumMgr managers share one subordinate port, responses routed via an owner FIFO.
// Optional USER_OBI_ARB_PERF_EN adds saturating grant/stall counters.
module user_obi_rr_arbiter #(
    parameter int NumMgr   = 4,
    parameter int MaxTrans = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NumMgr-1:0]      mgr_req_i,
    input  logic [NumMgr*32-1:0]   mgr_addr_i,
    input  logic [NumMgr-1:0]      mgr_we_i,
    input  logic [NumMgr*4-1:0]    mgr_be_i,
    input  logic [NumMgr*32-1:0]   mgr_wdata_i,
    output logic [NumMgr-1:0]      mgr_gnt_o,
    output logic [NumMgr-1:0]      mgr_rvalid_o,
    output logic [31:0]            mgr_rdata_o,
    output logic                   mgr_err_o,
    output logic                   sbr_req_o,
    output logic [31:0]            sbr_addr_o,
    output logic                   sbr_we_o,
    output logic [3:0]             sbr_be_o,
    output logic [31:0]            sbr_wdata_o,
    input  logic                   sbr_gnt_i,
    input  logic                   sbr_rvalid_i,
    input  logic [31:0]            sbr_rdata_i,
    input  logic                   sbr_err_i,
    output logic                   busy_o
`ifdef USER_OBI_ARB_PERF_EN
    ,
    output logic [31:0]            grant_cnt_o,
    output logic [31:0]            stall_cnt_o
`endif
);

    localparam int IW = $clog2(NumMgr);
    localparam int PW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
    localparam int CW = $clog2(MaxTrans + 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]    r_state;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_lock_idx;
    logic [IW-1:0] r_fifo [MaxTrans];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic [0:0]    w_state;
    logic [IW-1:0] w_ptr;
    logic [CW-1:0] w_count;
    logic [IW-1:0] w_head;
    logic [IW-1:0] w_scan;
    logic [IW-1:0] w_win_idx;
    logic          w_win_valid;
    logic          w_full;
    logic          w_push;
    logic          w_pop;

    function automatic logic [PW-1:0] fifo_inc(input logic [PW-1:0] p);
        return (p == PW'(MaxTrans - 1)) ? '0 : p + 1'b1;
    endfunction

    // While rst_i is high the outputs already reflect the state reset will leave behind.
    assign w_state = rst_i ? ST_IDLE : r_state;
    assign w_ptr   = rst_i ? '0 : r_ptr;
    assign w_count = rst_i ? '0 : r_count;
    assign w_head  = r_fifo[r_rd_ptr];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_win_valid = 1'b0;
        w_win_idx   = '0;
        w_scan      = '0;
        if (w_state == ST_LOCKED) begin
            w_win_valid = 1'b1;
            w_win_idx   = r_lock_idx;
        end else begin
            // Scan backwards so the last hit is the first requester from w_ptr.
            for (int k = NumMgr - 1; k >= 0; k--) begin
                w_scan = IW'((int'(w_ptr) + k) % NumMgr);
                if (mgr_req_i[w_scan]) begin
                    w_win_valid = 1'b1;
                    w_win_idx   = w_scan;
                end
            end
        end
    end

    assign w_full    = (w_count == CW'(MaxTrans));
    assign sbr_req_o = w_win_valid && !w_full;
    assign w_push    = sbr_req_o && sbr_gnt_i;
    assign w_pop     = sbr_rvalid_i && (w_count != '0);

    always_comb begin
        sbr_addr_o   = '0;
        sbr_we_o     = 1'b0;
        sbr_be_o     = '0;
        sbr_wdata_o  = '0;
        mgr_gnt_o    = '0;
        mgr_rvalid_o = '0;
        for (int k = 0; k < NumMgr; k++) begin
            if (sbr_req_o && (w_win_idx == IW'(k))) begin
                sbr_addr_o   = mgr_addr_i[k*32 +: 32];
                sbr_we_o     = mgr_we_i[k];
                sbr_be_o     = mgr_be_i[k*4 +: 4];
                sbr_wdata_o  = mgr_wdata_i[k*32 +: 32];
                mgr_gnt_o[k] = sbr_gnt_i;
            end
            if (w_pop && (w_head == IW'(k))) begin
                mgr_rvalid_o[k] = 1'b1;
            end
        end
    end

    assign mgr_rdata_o = w_pop ? sbr_rdata_i : '0;
    assign mgr_err_o   = w_pop && sbr_err_i;
    assign busy_o      = (w_state == ST_LOCKED) || (w_count != '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_lock_idx <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_state  <= ST_IDLE;
                r_ptr    <= (w_win_idx == IW'(NumMgr - 1)) ? '0 : w_win_idx + 1'b1;
                r_wr_ptr <= fifo_inc(r_wr_ptr);
            end else if (sbr_req_o) begin
                r_state    <= ST_LOCKED;
                r_lock_idx <= w_win_idx;
            end
            if (w_pop) begin
                r_rd_ptr <= fifo_inc(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // NOTE: owner storage is not reset; r_count guarantees stale entries are never read.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_push) begin
            r_fifo[r_wr_ptr] <= w_win_idx;
        end
    end

`ifdef USER_OBI_ARB_PERF_EN
    logic [31:0] r_grant_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_grant_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_push && (r_grant_cnt != '1)) begin
                r_grant_cnt <= r_grant_cnt + 1'b1;
            end
            if (sbr_req_o && !sbr_gnt_i && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign grant_cnt_o = rst_i ? '0 : r_grant_cnt;
    assign stall_cnt_o = rst_i ? '0 : r_stall_cnt;
`endif

endmodule

// File: tb/tb_user_obi_rr_arbiter.sv
// Self-checking bench for user_obi_rr_arbiter: directed scenarios then random traffic against a queue-based model.
module tb_user_obi_rr_arbiter;

    localparam int N  = 4;
    localparam int MT = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*32-1:0] addr;
    logic [N-1:0]    we;
    logic [N*4-1:0]  be;
    logic [N*32-1:0] wdata;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rvalid;
    logic [31:0]     rdata;
    logic            err;
    logic            sreq;
    logic [31:0]     saddr;
    logic            swe;
    logic [3:0]      sbe;
    logic [31:0]     swdata;
    logic            sgnt;
    logic            srv;
    logic [31:0]     srdata;
    logic            serr;
    logic            busy;
`ifdef USER_OBI_ARB_PERF_EN
    logic [31:0]     grant_cnt;
    logic [31:0]     stall_cnt;
`endif

    always #5 clk = ~clk;

    user_obi_rr_arbiter #(.NumMgr(N), .MaxTrans(MT)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .mgr_req_i    (req),
        .mgr_addr_i   (addr),
        .mgr_we_i     (we),
        .mgr_be_i     (be),
        .mgr_wdata_i  (wdata),
        .mgr_gnt_o    (gnt),
        .mgr_rvalid_o (rvalid),
        .mgr_rdata_o  (rdata),
        .mgr_err_o    (err),
        .sbr_req_o    (sreq),
        .sbr_addr_o   (saddr),
        .sbr_we_o     (swe),
        .sbr_be_o     (sbe),
        .sbr_wdata_o  (swdata),
        .sbr_gnt_i    (sgnt),
        .sbr_rvalid_i (srv),
        .sbr_rdata_i  (srdata),
        .sbr_err_i    (serr),
        .busy_o       (busy)
`ifdef USER_OBI_ARB_PERF_EN
        ,
        .grant_cnt_o  (grant_cnt),
        .stall_cnt_o  (stall_cnt)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: rotating priority start, lock flag, queue of response owners.
    int m_ptr = 0;
    bit m_locked = 1'b0;
    int m_lock = 0;
    int m_q[$];

    logic [31:0] s_gnt, s_rvalid, s_rdata, s_err, s_sreq, s_addr, s_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs are already applied; sample mid-cycle, compare, then advance model and clock.
    task automatic cycle(input string tag);
        int  ptr_e;
        bit  lk_e;
        int  q_e[$];
        int  w;
        bit  wv;
        bit  e_sreq;
        bit  e_pop;
        bit  e_push;
        logic [31:0] e_gnt, e_rv;
        #4;
        if (rst) begin
            ptr_e = 0;
            lk_e  = 1'b0;
            q_e   = {};
        end else begin
            ptr_e = m_ptr;
            lk_e  = m_locked;
            q_e   = m_q;
        end
        wv = 1'b0;
        w  = 0;
        if (lk_e) begin
            wv = 1'b1;
            w  = m_lock;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!wv && req[(ptr_e + k) % N]) begin
                    wv = 1'b1;
                    w  = (ptr_e + k) % N;
                end
            end
        end
        e_sreq = wv && (q_e.size() < MT);
        e_push = e_sreq && sgnt;
        e_pop  = srv && (q_e.size() > 0);
        e_gnt  = e_push ? (32'd1 << w) : 32'd0;
        e_rv   = e_pop ? (32'd1 << q_e[0]) : 32'd0;

        s_gnt    = 32'(gnt);
        s_rvalid = 32'(rvalid);
        s_rdata  = rdata;
        s_err    = 32'(err);
        s_sreq   = 32'(sreq);
        s_addr   = saddr;
        s_busy   = 32'(busy);

        check({tag, ".gnt"},    s_gnt, e_gnt);
        check({tag, ".rvalid"}, s_rvalid, e_rv);
        check({tag, ".rdata"},  s_rdata, e_pop ? srdata : 32'd0);
        check({tag, ".err"},    s_err, 32'(e_pop && serr));
        check({tag, ".sreq"},   s_sreq, 32'(e_sreq));
        check({tag, ".addr"},   s_addr, e_sreq ? addr[w*32 +: 32] : 32'd0);
        check({tag, ".we"},     32'(swe), 32'(e_sreq && we[w]));
        check({tag, ".be"},     32'(sbe), e_sreq ? 32'(be[w*4 +: 4]) : 32'd0);
        check({tag, ".wdata"},  swdata, e_sreq ? wdata[w*32 +: 32] : 32'd0);
        check({tag, ".busy"},   s_busy, 32'(lk_e || (q_e.size() > 0)));

        if (rst) begin
            m_ptr    = 0;
            m_locked = 1'b0;
            m_lock   = 0;
            m_q      = {};
        end else begin
            if (e_pop) q_e.delete(0);
            if (e_push) begin
                q_e.push_back(w);
                ptr_e = (w + 1) % N;
                lk_e  = 1'b0;
            end else if (e_sreq) begin
                lk_e   = 1'b1;
                m_lock = w;
            end
            m_ptr    = ptr_e;
            m_locked = lk_e;
            m_q      = q_e;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req = '0; sgnt = 1'b0; srv = 1'b0; srdata = '0; serr = 1'b0;
        we = 4'b1010; be = '0; addr = '0; wdata = '0;
        for (int i = 0; i < N; i++) begin
            addr[i*32 +: 32]  = 32'h1000_0000 + 32'(i * 4);
            wdata[i*32 +: 32] = 32'hA5A5_0000 + 32'(i);
            be[i*4 +: 4]      = 4'(i + 1);
        end
        addr[2*32 +: 32] = 32'h2000_0010;
        @(posedge clk);
        #1;

        cycle("rst0");
        check("rst0.busy_zero", s_busy, 32'd0);
        rst = 1'b0;

        // All four requesting, immediate grants, responses one cycle later.
        req = 4'b1111; sgnt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            srv = (m_q.size() > 0);
            cycle($sformatf("rr%0d", i));
            check($sformatf("rr%0d.order", i), s_gnt, 32'd1 << (i % 4));
        end
        req = '0; srv = 1'b1;
        cycle("rr_drain");
        srv = 1'b0;
        cycle("rr_idle");
        check("rr_idle.busy", s_busy, 32'd0);

        // Manager 2 held off by the subordinate; manager 0 must not steal the port.
        req = 4'b0100; sgnt = 1'b0;
        cycle("lk0");
        check("lk0.addr", s_addr, 32'h2000_0010);
        req = 4'b0101;
        for (int i = 1; i < 3; i++) begin
            cycle($sformatf("lk%0d", i));
            check($sformatf("lk%0d.addr", i), s_addr, 32'h2000_0010);
            check($sformatf("lk%0d.busy", i), s_busy, 32'd1);
        end
        sgnt = 1'b1;
        cycle("lk_gnt");
        check("lk_gnt.onehot", s_gnt, 32'b0100);
        req = 4'b0001;
        cycle("lk_next");
        check("lk_next.mgr0", s_gnt, 32'b0001);
        req = '0; srv = 1'b1; srdata = 32'h1234_5678;
        cycle("lk_r0");
        check("lk_r0.owner", s_rvalid, 32'b0100);
        cycle("lk_r1");
        check("lk_r1.owner", s_rvalid, 32'b0001);
        srv = 1'b0;

        // Owner FIFO full gates the request, even on a same-cycle pop.
        req = 4'b1111; sgnt = 1'b1;
        cycle("full0");
        cycle("full1");
        cycle("full2");
        check("full2.gated", s_sreq, 32'd0);
        check("full2.busy", s_busy, 32'd1);
        srv = 1'b1;
        cycle("full3");
        check("full3.gated_pop", s_sreq, 32'd0);
        srv = 1'b0;
        cycle("full4");
        check("full4.resume", s_sreq, 32'd1);
        check("full4.busy", s_busy, 32'd1);
        req = '0; srv = 1'b1;
        cycle("full_d0");
        cycle("full_d1");
        srv = 1'b0;

        // Response routing and error forwarding.
        req = 4'b0010;
        cycle("rsp_g1");
        check("rsp_g1.gnt", s_gnt, 32'b0010);
        req = 4'b1000;
        cycle("rsp_g3");
        check("rsp_g3.gnt", s_gnt, 32'b1000);
        req = '0; srv = 1'b1; srdata = 32'hDEAD_BEEF; serr = 1'b0;
        cycle("rsp0");
        check("rsp0.owner", s_rvalid, 32'b0010);
        check("rsp0.data", s_rdata, 32'hDEAD_BEEF);
        srdata = 32'h1; serr = 1'b1;
        cycle("rsp1");
        check("rsp1.owner", s_rvalid, 32'b1000);
        check("rsp1.err", s_err, 32'd1);

        // Spurious response, then reset with one transaction in flight.
        srdata = 32'hCAFE_0000; serr = 1'b1;
        cycle("spur");
        check("spur.none", s_rvalid, 32'd0);
        check("spur.rdata", s_rdata, 32'd0);
        srv = 1'b0; serr = 1'b0; req = 4'b0001;
        cycle("mid_g");
        req = '0;
        cycle("mid_busy");
        check("mid_busy.busy", s_busy, 32'd1);
        rst = 1'b1;
        cycle("mid_rst");
        check("mid_rst.busy", s_busy, 32'd0);
        rst = 1'b0; srv = 1'b1;
        cycle("post_rst");
        check("post_rst.ignored", s_rvalid, 32'd0);
        check("post_rst.busy", s_busy, 32'd0);
        srv = 1'b0; req = 4'b1111;
        cycle("post_rst_g");
        check("post_rst_g.ptr0", s_gnt, 32'b0001);
        req = '0; srv = 1'b1;
        cycle("post_rst_d");
        srv = 1'b0;

`ifdef USER_OBI_ARB_PERF_EN
        rst = 1'b1;
        cycle("perf_rst");
        rst = 1'b0; req = 4'b0001; sgnt = 1'b0;
        for (int i = 0; i < 3; i++) cycle($sformatf("perf_st%0d", i));
        sgnt = 1'b1;
        cycle("perf_g0");
        req = 4'b1111;
        for (int i = 1; i < 5; i++) begin
            srv = (m_q.size() > 0);
            cycle($sformatf("perf_g%0d", i));
        end
        req = '0; srv = 1'b1;
        #4;
        check("perf.grant_cnt", grant_cnt, 32'd5);
        check("perf.stall_cnt", stall_cnt, 32'd3);
        @(posedge clk);
        #1;
        srv = 1'b0;
`endif

        // Random traffic, including occasional mid-stream resets.
        for (int c = 0; c < 400; c++) begin
            rst    = ($urandom_range(0, 49) == 0);
            req    = N'($urandom);
            sgnt   = ($urandom_range(0, 3) != 0);
            srv    = ($urandom_range(0, 2) != 0);
            srdata = $urandom;
            serr   = 1'($urandom);
            we     = N'($urandom);
            be     = (N*4)'($urandom);
            for (int i = 0; i < N; i++) begin
                addr[i*32 +: 32]  = $urandom;
                wdata[i*32 +: 32] = $urandom;
            end
            cycle($sformatf("rnd%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
